ntt_seq_ctrl: RTL and testbench
===============================

Name: ntt_seq_ctrl

Overview:
- Sequencer for one dit_butterfly instance and a dual-port coefficient RAM.
- Runs a full in-place radix-2 DIT NTT, one butterfly per cycle, over N = 2^LOGN coefficients. The data is already in bit-reversed order.
- Alternatively runs a single pointwise-multiply pass.
- Generates RAM read addresses, twiddle ROM address and butterfly mode/swap. Delays the addresses to the butterfly output as write-backs, and stalls between stages until all writes have landed.

Parameters:
- LOGN, 8, log2 of transform size N.
- RD_LATENCY, 1, cycles from rd_en/addr to RAM data at butterfly inputs. Twiddle ROM has the same latency.
- BF_LATENCY, 8, cycles from butterfly inputs to A_out/B_out valid.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- op_mode  in  1  0 = NTT, 1 = pointwise multiply; latched at start.
- busy  out  1  high from the cycle after start is accepted until the done cycle inclusive.
- done  out  1  one-cycle pulse after the final write.
- rd_en  out  1  RAM read strobe, both ports.
- rd_addr_a  out  LOGN  port-A read address.
- rd_addr_b  out  LOGN  port-B read address.
- tw_addr  out  LOGN-1 (NTT) / LOGN (mult); physical width LOGN  twiddle/operand ROM address.
- bf_mode  out  1  to butterfly mode. Delayed RD_LATENCY to align with data.
- bf_swap  out  1  to butterfly swap. Delayed RD_LATENCY to align with data.
- wr_en_a  out  1  port-A write enable.
- wr_en_b  out  1  port-B write enable.
- wr_addr_a  out  LOGN  port-A write address.
- wr_addr_b  out  LOGN  port-B write address.

Behaviour:
- D = RD_LATENCY + BF_LATENCY. Write-back path is a D-deep shift register of {wr_en_a, wr_en_b, addr_a, addr_b}, fed from the issue-cycle signals.
- Reset (reset_n=0 at an edge) clears all outputs and the shift register to 0 and forces IDLE, including mid-operation. In-flight writes are discarded.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE -> ISSUE when start=1. op_mode is latched; stage s=0, counter c=0.
- ISSUE, NTT mode:
  - rd_en=1 every cycle.
  - m = 2^s; j = c mod m; k = c div m.
  - rd_addr_a = k*2m + j; rd_addr_b = rd_addr_a + m.
  - tw_addr = j << (LOGN-1-s).
  - bf_mode=0, bf_swap=0; write-back carries wr_en_a = wr_en_b = 1.
  - After c = N/2-1, go to DRAIN.
- ISSUE, multiply mode:
  - c runs 0..N-1; rd_addr_a = c, rd_addr_b = 0, tw_addr = c.
  - bf_mode=1, bf_swap=1; write-back carries wr_en_a=1, wr_en_b=0.
- DRAIN: rd_en=0; wait until the shift register holds no valid entry.
  - NTT with s < LOGN-1: s++, c=0, back to ISSUE. First read of the next stage occurs the cycle after the last write.
  - Otherwise go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- start while busy is ignored. start and reset_n=0 in the same cycle: reset wins.
- Address arithmetic is modulo 2^LOGN. No address ever exceeds N-1.
- Timing (start sampled at cycle 0, first rd_en at cycle 1):
  - NTT: done at cycle LOGN*(N/2 + D) + 1.
  - Multiply: done at cycle N + D + 1.

Test Plan:
- LOGN=3, D=5, NTT, start at cycle 0:
  - Stage 0: reads (0,1)(2,3)(4,5)(6,7) at cycles 1-4, tw 0,0,0,0; writes same pairs at cycles 6-9.
  - Stage 1: reads (0,2)(1,3)(4,6)(5,7) at cycles 10-13, tw 0,2,0,2.
  - Stage 2: reads (0,4)(1,5)(2,6)(3,7) at cycles 19-22, tw 0,1,2,3.
  - done at cycle 28.
- Same config, multiply mode:
  - rd_addr_a 0..7 at cycles 1-8, tw_addr = rd_addr_a, bf_mode=1, bf_swap=1.
  - wr_en_a at cycles 6-13, wr_en_b never; done at cycle 14.
- Full NTT on a RAM model with q=17 and a real butterfly, N=8, input x=[1,0,...,0] bit-reversed -> all outputs 1.
- start pulsed at cycles 3 and 15 during an NTT -> ignored; schedule identical to the first scenario.
- reset_n=0 at cycle 12 of an NTT:
  - At cycle 13: rd_en, wr_en_a/b, busy, done are all 0; FSM is IDLE.
  - No writes after reset deasserts; a new start runs a clean schedule.
- LOGN=8 NTT -> exactly 1024 write pairs, no address repeated within a stage; done at cycle 8*(128+D)+1.

Source files
------------

// File: rtl/ntt_seq_ctrl_if.sv
// Control/bus bundle between the NTT sequencer, its host and the RAM/butterfly datapath.
// master = sequencer side; slave = host/datapath side.
interface ntt_seq_ctrl_if #(
   parameter int unsigned LOGN = 8
);
   logic            start;
   logic            op_mode;
   logic            busy;
   logic            done;
   logic            rd_en;
   logic [LOGN-1:0] rd_addr_a;
   logic [LOGN-1:0] rd_addr_b;
   logic [LOGN-1:0] tw_addr;
   logic            bf_mode;
   logic            bf_swap;
   logic            wr_en_a;
   logic            wr_en_b;
   logic [LOGN-1:0] wr_addr_a;
   logic [LOGN-1:0] wr_addr_b;

   modport master (
      input  start, op_mode,
      output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode, bf_swap,
      output wr_en_a, wr_en_b, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start, op_mode,
      input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_mode, bf_swap,
      input  wr_en_a, wr_en_b, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/ntt_seq_ctrl.sv
// In-place radix-2 DIT NTT / pointwise-multiply sequencer: issues one butterfly per cycle,
// delays addresses to the butterfly output as write-backs and stalls between stages.
module ntt_seq_ctrl #(
   parameter int unsigned LOGN       = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned BF_LATENCY = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   ntt_seq_ctrl_if.master bus
);
   localparam int unsigned N  = 1 << LOGN;
   localparam int unsigned D  = RD_LATENCY + BF_LATENCY;
   localparam int unsigned SW = (LOGN > 1) ? $clog2(LOGN) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

   typedef struct packed {
      logic            en_a;
      logic            en_b;
      logic [LOGN-1:0] addr_a;
      logic [LOGN-1:0] addr_b;
   } wb_t;

   state_e          state_q, state_d;
   logic            mult_q, mult_d;
   logic [SW-1:0]   s_q, s_d;
   logic [LOGN-1:0] c_q, c_d;

   wb_t             wb_q [D];
   wb_t             wb_in;
   logic            bf_ctl_q [RD_LATENCY];

   logic            issue;
   logic            last_c;
   logic            pending;
   logic [LOGN-1:0] mask, j_val, hi_val;
   logic [LOGN-1:0] ntt_a, ntt_b, ntt_tw;
   logic [LOGN-1:0] iss_a, iss_b, iss_tw;

   // k*2m + j is c with the bits at and above s shifted up by one; +m sets bit s.
   always_comb begin
      mask   = (LOGN'(1) << s_q) - LOGN'(1);
      j_val  = c_q & mask;
      hi_val = c_q & ~mask;
      ntt_a  = (hi_val << 1) | j_val;
      ntt_b  = ntt_a | (LOGN'(1) << s_q);
      ntt_tw = j_val << (SW'(LOGN - 1) - s_q);
   end

   always_comb begin
      issue  = (state_q == StIssue);
      iss_a  = mult_q ? c_q : ntt_a;
      iss_b  = mult_q ? '0  : ntt_b;
      iss_tw = mult_q ? c_q : ntt_tw;
      last_c = mult_q ? (c_q == LOGN'(N - 1)) : (c_q == LOGN'(N / 2 - 1));

      wb_in.en_a   = issue;
      wb_in.en_b   = issue & ~mult_q;
      wb_in.addr_a = issue ? iss_a : '0;
      wb_in.addr_b = issue ? iss_b : '0;
   end

   // Entries that will still be in flight after the next edge; the oldest one writes now.
   always_comb begin
      pending = 1'b0;
      for (int unsigned i = 0; i + 1 < D; i++) begin
         pending = pending | wb_q[i].en_a | wb_q[i].en_b;
      end
   end

   always_comb begin
      state_d = state_q;
      mult_d  = mult_q;
      s_d     = s_q;
      c_d     = c_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StIssue;
               mult_d  = bus.op_mode;
               s_d     = '0;
               c_d     = '0;
            end
         end
         StIssue: begin
            c_d = c_q + 1'b1;
            if (last_c) begin
               state_d = StDrain;
               c_d     = '0;
            end
         end
         StDrain: begin
            if (!pending) begin
               if (!mult_q && (s_q != SW'(LOGN - 1))) begin
                  s_d     = s_q + 1'b1;
                  state_d = StIssue;
               end else begin
                  state_d = StFinish;
               end
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         mult_q  <= 1'b0;
         s_q     <= '0;
         c_q     <= '0;
         for (int unsigned i = 0; i < D; i++) begin
            wb_q[i] <= '0;
         end
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            bf_ctl_q[i] <= 1'b0;
         end
      end else begin
         state_q  <= state_d;
         mult_q   <= mult_d;
         s_q      <= s_d;
         c_q      <= c_d;
         wb_q[0]  <= wb_in;
         for (int unsigned i = 1; i < D; i++) begin
            wb_q[i] <= wb_q[i-1];
         end
         bf_ctl_q[0] <= issue & mult_q;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            bf_ctl_q[i] <= bf_ctl_q[i-1];
         end
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = (state_q == StFinish);
   assign bus.rd_en     = issue;
   assign bus.rd_addr_a = issue ? iss_a : '0;
   assign bus.rd_addr_b = issue ? iss_b : '0;
   assign bus.tw_addr   = issue ? iss_tw : '0;
   // Mode and swap coincide in both operations, so one delay line serves both.
   assign bus.bf_mode   = bf_ctl_q[RD_LATENCY-1];
   assign bus.bf_swap   = bf_ctl_q[RD_LATENCY-1];
   assign bus.wr_en_a   = wb_q[D-1].en_a;
   assign bus.wr_en_b   = wb_q[D-1].en_b;
   assign bus.wr_addr_a = wb_q[D-1].addr_a;
   assign bus.wr_addr_b = wb_q[D-1].addr_b;
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: LOGN=3 schedule/data checks and a LOGN=8 full-size NTT sweep.
module tb_ntt_seq_ctrl;
   localparam int RDL = 1;
   localparam int BFL = 4;
   localparam int D   = RDL + BFL;

   typedef struct {
      int cyc;
      int a;
      int b;
      int tw;
      bit mult;
   } rd_t;

   typedef struct {
      int cyc;
      int a;
      int b;
      bit wb;
      int va;
      int vb;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   rd_t  ntt_tab [12];
   rd_t  exp_rd [$];
   wr_t  sb [$];
   int   ram [8];
   bit   seen [8][256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ntt_seq_ctrl_if #(.LOGN(3)) sif ();
   ntt_seq_ctrl_if #(.LOGN(8)) bif ();

   ntt_seq_ctrl #(.LOGN(3), .RD_LATENCY(RDL), .BF_LATENCY(BFL)) u_small (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sif.master)
   );

   ntt_seq_ctrl #(.LOGN(8), .RD_LATENCY(RDL), .BF_LATENCY(BFL)) u_big (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bif.master)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int pw(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = (r * 2) % 17;
      return r;
   endfunction

   task automatic load_ntt();
      exp_rd.delete();
      foreach (ntt_tab[i]) exp_rd.push_back(ntt_tab[i]);
   endtask

   task automatic load_mult();
      rd_t e;
      exp_rd.delete();
      for (int c = 0; c < 8; c++) begin
         e = '{1 + c, c, 0, c, 1'b1};
         exp_rd.push_back(e);
      end
   endtask

   task automatic run_small(input bit mult, input bit pulse, input int rst_at, input int done_exp);
      int  t0, rel, act;
      bit  got_done = 0;
      bit  prev_rd = 0;
      bit  prev_mult = 0;
      rd_t e;
      wr_t w;
      int  wt, t;
      sb.delete();
      foreach (ram[i]) ram[i] = (i == 0) ? 1 : 0;
      @(negedge clk);
      check("busy_before_start", int'(sif.busy), 0);
      sif.start = 1'b1;
      sif.op_mode = mult;
      t0 = cyc;
      @(negedge clk);
      sif.start = 1'b0;
      sif.op_mode = 1'b0;
      for (int n = 0; n < 200; n++) begin
         rel = cyc - t0;
         sif.start = (pulse && (rel == 3 || rel == 15)) ? 1'b1 : 1'b0;
         if (rst_at > 0 && rel == rst_at) reset_n = 1'b0;
         if (rst_at > 0 && rel == rst_at + 1) begin
            check("rst_rd_en", int'(sif.rd_en), 0);
            check("rst_wr_en_a", int'(sif.wr_en_a), 0);
            check("rst_wr_en_b", int'(sif.wr_en_b), 0);
            check("rst_busy", int'(sif.busy), 0);
            check("rst_done", int'(sif.done), 0);
            reset_n = 1'b1;
            break;
         end
         if (prev_rd) begin
            check($sformatf("bf_mode@%0d", rel), int'(sif.bf_mode), int'(prev_mult));
            check($sformatf("bf_swap@%0d", rel), int'(sif.bf_swap), int'(prev_mult));
         end
         prev_rd = sif.rd_en;
         if (sif.rd_en) begin
            if (exp_rd.size() == 0) begin
               check($sformatf("extra_read@%0d", rel), 1, 0);
               prev_mult = mult;
            end else begin
               e = exp_rd.pop_front();
               prev_mult = e.mult;
               check($sformatf("rd_cycle(a=%0d)", e.a), rel, e.cyc);
               check($sformatf("rd_addr_a@%0d", rel), int'(sif.rd_addr_a), e.a);
               check($sformatf("rd_addr_b@%0d", rel), int'(sif.rd_addr_b), e.b);
               check($sformatf("tw_addr@%0d", rel), int'(sif.tw_addr), e.tw);
               wt = pw(e.tw);
               t = (wt * ram[e.b]) % 17;
               w = '{rel + D, e.a, e.b, !e.mult, (ram[e.a] + t) % 17, (ram[e.a] - t + 17) % 17};
               sb.push_back(w);
            end
         end
         if (sif.wr_en_a || sif.wr_en_b) begin
            if (sb.size() == 0) begin
               check($sformatf("extra_write@%0d", rel), 1, 0);
            end else begin
               w = sb.pop_front();
               check($sformatf("wr_cycle(a=%0d)", w.a), rel, w.cyc);
               check($sformatf("wr_en_a@%0d", rel), int'(sif.wr_en_a), 1);
               check($sformatf("wr_en_b@%0d", rel), int'(sif.wr_en_b), int'(w.wb));
               check($sformatf("wr_addr_a@%0d", rel), int'(sif.wr_addr_a), w.a);
               if (w.wb) check($sformatf("wr_addr_b@%0d", rel), int'(sif.wr_addr_b), w.b);
               ram[w.a] = w.va;
               if (w.wb) ram[w.b] = w.vb;
            end
         end
         check($sformatf("busy@%0d", rel), int'(sif.busy), 1);
         if (sif.done) begin
            check("done_cycle", rel, done_exp);
            got_done = 1;
            break;
         end
         @(negedge clk);
      end
      if (rst_at > 0) begin
         act = 0;
         exp_rd.delete();
         sb.delete();
         repeat (20) begin
            @(negedge clk);
            if (sif.rd_en || sif.wr_en_a || sif.wr_en_b || sif.busy || sif.done) act++;
         end
         check("activity_after_reset", act, 0);
      end else begin
         check("done_seen", int'(got_done), 1);
         check("reads_left", exp_rd.size(), 0);
         check("writes_left", sb.size(), 0);
         @(negedge clk);
         check("busy_after_done", int'(sif.busy), 0);
         check("done_one_cycle", int'(sif.done), 0);
      end
   endtask

   task automatic run_big();
      rd_t e;
      int  t0, rel, m;
      int  rd_bad = 0, rd_cnt = 0, pairs = 0, singles = 0, dups = 0, stg;
      bit  got_done = 0;
      exp_rd.delete();
      for (int s = 0; s < 8; s++) begin
         m = 1 << s;
         for (int k = 0; k < 256 / (2 * m); k++) begin
            for (int j = 0; j < m; j++) begin
               e = '{0, k * 2 * m + j, k * 2 * m + j + m, j << (7 - s), 1'b0};
               exp_rd.push_back(e);
            end
         end
      end
      for (int s = 0; s < 8; s++) for (int a = 0; a < 256; a++) seen[s][a] = 1'b0;
      @(negedge clk);
      bif.start = 1'b1;
      bif.op_mode = 1'b0;
      t0 = cyc;
      @(negedge clk);
      bif.start = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rel = cyc - t0;
         if (bif.rd_en) begin
            rd_cnt++;
            if (exp_rd.size() == 0) begin
               rd_bad++;
            end else begin
               e = exp_rd.pop_front();
               if (int'(bif.rd_addr_a) != e.a || int'(bif.rd_addr_b) != e.b ||
                   int'(bif.tw_addr) != e.tw) rd_bad++;
            end
         end
         if (bif.wr_en_a && bif.wr_en_b) begin
            stg = pairs / 128;
            if (stg > 7) stg = 7;
            if (seen[stg][bif.wr_addr_a] || seen[stg][bif.wr_addr_b] ||
                bif.wr_addr_a == bif.wr_addr_b) dups++;
            seen[stg][bif.wr_addr_a] = 1'b1;
            seen[stg][bif.wr_addr_b] = 1'b1;
            pairs++;
         end else if (bif.wr_en_a || bif.wr_en_b) begin
            singles++;
         end
         if (bif.done) begin
            check("big_done_cycle", rel, 8 * (128 + D) + 1);
            got_done = 1;
            break;
         end
         @(negedge clk);
      end
      check("big_done_seen", int'(got_done), 1);
      check("big_read_count", rd_cnt, 1024);
      check("big_read_mismatches", rd_bad, 0);
      check("big_write_pairs", pairs, 1024);
      check("big_single_writes", singles, 0);
      check("big_repeated_addr", dups, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ntt_tab[0]  = '{1, 0, 1, 0, 1'b0};
      ntt_tab[1]  = '{2, 2, 3, 0, 1'b0};
      ntt_tab[2]  = '{3, 4, 5, 0, 1'b0};
      ntt_tab[3]  = '{4, 6, 7, 0, 1'b0};
      ntt_tab[4]  = '{10, 0, 2, 0, 1'b0};
      ntt_tab[5]  = '{11, 1, 3, 2, 1'b0};
      ntt_tab[6]  = '{12, 4, 6, 0, 1'b0};
      ntt_tab[7]  = '{13, 5, 7, 2, 1'b0};
      ntt_tab[8]  = '{19, 0, 4, 0, 1'b0};
      ntt_tab[9]  = '{20, 1, 5, 1, 1'b0};
      ntt_tab[10] = '{21, 2, 6, 2, 1'b0};
      ntt_tab[11] = '{22, 3, 7, 3, 1'b0};

      sif.start = 1'b0;
      sif.op_mode = 1'b0;
      bif.start = 1'b0;
      bif.op_mode = 1'b0;
      reset_n = 1'b0;
      sif.start = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", int'(sif.busy), 0);
      check("reset_done", int'(sif.done), 0);
      check("reset_rd_en", int'(sif.rd_en), 0);
      check("reset_wr_en_a", int'(sif.wr_en_a), 0);
      check("reset_wr_en_b", int'(sif.wr_en_b), 0);
      check("reset_rd_addr_b", int'(sif.rd_addr_b), 0);
      sif.start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_busy", int'(sif.busy), 0);

      load_ntt();
      run_small(1'b0, 1'b0, 0, 28);
      for (int i = 0; i < 8; i++) check($sformatf("ntt_out[%0d]", i), ram[i], 1);

      load_mult();
      run_small(1'b1, 1'b0, 0, 14);

      load_ntt();
      run_small(1'b0, 1'b1, 0, 28);

      load_ntt();
      run_small(1'b0, 1'b0, 12, 0);

      load_ntt();
      run_small(1'b0, 1'b0, 0, 28);
      for (int i = 0; i < 8; i++) check($sformatf("ntt_out_post_rst[%0d]", i), ram[i], 1);

      run_big();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
